step_seq_ctrl: RTL



---
 rtl/step_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/step_seq_ctrl.sv
// Sequencer tempo/step controller: divides clk into step periods, advances a
// modulo-STEPS step index, supports clamped jumps and emits a per-step gate.
module step_seq_ctrl #(
    parameter int STEPS  = 16,
    parameter int SW     = 4,
    parameter int DIV_W  = 16,
    parameter int GATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              jump,
    input  logic [SW-1:0]     jump_step,
    input  logic [DIV_W-1:0]  tick_div,
    input  logic [GATE_W-1:0] gate_len,
    output logic [SW-1:0]     step,
    output logic              step_stb,
    output logic              gate,
    output logic              wrap,
    output logic              running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    state_t            state_reg;
    logic [SW-1:0]     step_reg;
    logic [DIV_W-1:0]  presc_reg;
    logic [GATE_W-1:0] gcnt_reg;
    logic              step_stb_reg;
    logic              gate_reg;
    logic              wrap_reg;
    logic              running_reg;

    logic [SW-1:0]     jump_tgt;
    logic [SW-1:0]     step_next;
    logic              tick;
    logic              gate_on;
    logic              gate_end;

    always_comb begin
        jump_tgt  = (jump_step > LAST_STEP) ? LAST_STEP : jump_step;
        step_next = (step_reg == LAST_STEP) ? '0 : step_reg + 1'b1;
        // >= so that shrinking tick_div mid-period ticks at once instead of running away
        tick      = (presc_reg >= tick_div);
        gate_on   = (gate_len != '0);
        gate_end  = (gcnt_reg == gate_len - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            step_reg     <= '0;
            presc_reg    <= '0;
            gcnt_reg     <= '0;
            step_stb_reg <= 1'b0;
            gate_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            step_stb_reg <= 1'b0;
            wrap_reg     <= 1'b0;
            if (stop) begin
                state_reg   <= IDLE;
                step_reg    <= '0;
                presc_reg   <= '0;
                gcnt_reg    <= '0;
                gate_reg    <= 1'b0;
                running_reg <= 1'b0;
            end else if (jump) begin
                step_reg  <= jump_tgt;
                presc_reg <= '0;
                if (state_reg == RUN) begin
                    step_stb_reg <= 1'b1;
                    gcnt_reg     <= '0;
                    gate_reg     <= gate_on;
                end
            end else if (pause && state_reg == RUN) begin
                state_reg   <= PAUSE;
                running_reg <= 1'b0;
                gate_reg    <= 1'b0;
                // The cycle ending here was still run time; a tick that is due waits for resume.
                if (!tick) begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end else if (start && state_reg == IDLE) begin
                state_reg    <= RUN;
                running_reg  <= 1'b1;
                step_reg     <= '0;
                presc_reg    <= '0;
                gcnt_reg     <= '0;
                step_stb_reg <= 1'b1;
                gate_reg     <= gate_on;
            end else if (start && state_reg == PAUSE) begin
                state_reg   <= RUN;
                running_reg <= 1'b1;
            end else if (state_reg == RUN) begin
                if (tick) begin
                    presc_reg    <= '0;
                    step_reg     <= step_next;
                    step_stb_reg <= 1'b1;
                    wrap_reg     <= (step_reg == LAST_STEP);
                    gcnt_reg     <= '0;
                    gate_reg     <= gate_on;
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                    if (gate_reg) begin
                        if (gate_end) begin
                            gate_reg <= 1'b0;
                        end else begin
                            gcnt_reg <= gcnt_reg + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign step     = step_reg;
    assign step_stb = step_stb_reg;
    assign gate     = gate_reg;
    assign wrap     = wrap_reg;
    assign running  = running_reg;

endmodule
